// File: rtl/vga_cursor_ctrl.sv
// Text-mode cursor position, scroll request and blink/visibility generation.
// Optional blink logic is enabled by defining VGA_CURSOR_BLINK_EN.
module vga_cursor_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd,
    input  logic [11:0] i_cmd_data,
    input  logic        i_frame_strobe,
    input  logic        i_cursor_en,
    input  logic        i_scroll_done,
    output logic        o_scroll_req,
    output logic [6:0]  o_cur_col,
    output logic [4:0]  o_cur_row,
    output logic [11:0] o_cur_pos_addr,
    output logic        o_cur_visible,
    output logic [1:0]  o_dbg_state
);

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_RIGHT   = 3'd1;
    localparam logic [2:0] CMD_LEFT    = 3'd2;
    localparam logic [2:0] CMD_UP      = 3'd3;
    localparam logic [2:0] CMD_DOWN    = 3'd4;
    localparam logic [2:0] CMD_HOME    = 3'd5;
    localparam logic [2:0] CMD_NEWLINE = 3'd6;
    localparam logic [2:0] CMD_SET     = 3'd7;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    // Valid/ready: a command transfers on a rising edge where i_cmd_valid and
    // o_cmd_ready are both high; ready is high only in IDLE.
    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_EXEC        = 2'd1,
        S_SCROLL_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] addr_q, addr_d;
    logic        cmd_accept;
    logic        need_scroll;

    assign cmd_accept = i_cmd_valid && (state_q == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (cmd_accept) state_d = need_scroll ? S_SCROLL_WAIT : S_EXEC;
            S_EXEC:        state_d = S_IDLE;
            S_SCROLL_WAIT: if (i_scroll_done) state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready  = (state_q == S_IDLE);
        o_scroll_req = (state_q == S_SCROLL_WAIT);
        o_dbg_state  = state_q;
    end

    // Position update happens on the accept edge; a scroll keeps the row.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        need_scroll = 1'b0;
        if (cmd_accept) begin
            case (i_cmd)
                CMD_RIGHT: begin
                    if (col_q == LAST_COL) begin
                        col_d = 7'd0;
                        if (row_q == LAST_ROW) need_scroll = 1'b1;
                        else                   row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
                CMD_LEFT: begin
                    if (col_q != 7'd0) begin
                        col_d = col_q - 7'd1;
                    end else if (row_q != 5'd0) begin
                        col_d = LAST_COL;
                        row_d = row_q - 5'd1;
                    end
                end
                CMD_UP: if (row_q != 5'd0) row_d = row_q - 5'd1;
                CMD_DOWN: begin
                    if (row_q == LAST_ROW) need_scroll = 1'b1;
                    else                   row_d = row_q + 5'd1;
                end
                CMD_HOME: begin
                    col_d = 7'd0;
                    row_d = 5'd0;
                end
                CMD_NEWLINE: begin
                    col_d = 7'd0;
                    if (row_q == LAST_ROW) need_scroll = 1'b1;
                    else                   row_d = row_q + 5'd1;
                end
                CMD_SET: begin
                    if ((int'(i_cmd_data[6:0]) < COLS) && (int'(i_cmd_data[11:7]) < ROWS)) begin
                        col_d = i_cmd_data[6:0];
                        row_d = i_cmd_data[11:7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q != S_IDLE) addr_d = 12'(row_q) * 12'(COLS) + 12'(col_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q  <= 7'd0;
            row_q  <= 5'd0;
            addr_q <= 12'd0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign o_cur_col      = col_q;
    assign o_cur_row      = row_q;
    assign o_cur_pos_addr = addr_q;

`ifdef VGA_CURSOR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // A movement restart takes priority over a coincident frame strobe.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (cmd_accept && (i_cmd != CMD_NOP)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (i_frame_strobe) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign o_cur_visible = i_cursor_en && phase_q && (state_q != S_SCROLL_WAIT);
`else
    logic unused_frame_strobe;
    assign unused_frame_strobe = i_frame_strobe;
    assign o_cur_visible       = i_cursor_en && (state_q != S_SCROLL_WAIT);
`endif

endmodule

// File: tb/tb_vga_cursor_ctrl.sv
// Self-checking bench for vga_cursor_ctrl: movement commands, wrap/saturation,
// scroll handshake, throughput, reset abort and cursor visibility.
module tb_vga_cursor_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int BF   = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd = 3'd0;
    logic [11:0] i_cmd_data = 12'd0;
    logic        i_frame_strobe = 1'b0;
    logic        i_cursor_en = 1'b1;
    logic        i_scroll_done = 1'b0;
    logic        o_scroll_req;
    logic [6:0]  o_cur_col;
    logic [4:0]  o_cur_row;
    logic [11:0] o_cur_pos_addr;
    logic        o_cur_visible;
    logic [1:0]  o_dbg_state;

    vga_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd(i_cmd), .i_cmd_data(i_cmd_data), .i_frame_strobe(i_frame_strobe),
        .i_cursor_en(i_cursor_en), .i_scroll_done(i_scroll_done), .o_scroll_req(o_scroll_req),
        .o_cur_col(o_cur_col), .o_cur_row(o_cur_row), .o_cur_pos_addr(o_cur_pos_addr),
        .o_cur_visible(o_cur_visible), .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int m_col = 0;
    int m_row = 0;
    logic [23:0] exp_q[$];

    // ---------------- clock / reset ----------------
    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        m_col = 0;
        m_row = 0;
        exp_q.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_cmd(input logic [2:0] c, input logic [11:0] d);
        bit sc = 1'b0;
        case (c)
            3'd1: if (m_col == COLS - 1) begin
                      m_col = 0;
                      if (m_row == ROWS - 1) sc = 1'b1; else m_row++;
                  end else m_col++;
            3'd2: if (m_col > 0) m_col--;
                  else if (m_row > 0) begin m_col = COLS - 1; m_row--; end
            3'd3: if (m_row > 0) m_row--;
            3'd4: if (m_row == ROWS - 1) sc = 1'b1; else m_row++;
            3'd5: begin m_col = 0; m_row = 0; end
            3'd6: begin m_col = 0; if (m_row == ROWS - 1) sc = 1'b1; else m_row++; end
            3'd7: if (int'(d[6:0]) < COLS && int'(d[11:7]) < ROWS) begin
                      m_col = int'(d[6:0]);
                      m_row = int'(d[11:7]);
                  end
            default: ;
        endcase
        return sc;
    endfunction

    // ---------------- drivers ----------------
    task automatic pulse_done();
        @(negedge i_clk);
        i_scroll_done = 1'b1;
        @(posedge i_clk);
        #1 i_scroll_done = 1'b0;
    endtask

    task automatic pulse_strobe();
        @(negedge i_clk);
        i_frame_strobe = 1'b1;
        @(posedge i_clk);
        #1 i_frame_strobe = 1'b0;
        repeat (9) @(posedge i_clk);
    endtask

    // Drives one command and scoreboards position (accept edge) and address (one edge later).
    task automatic send(input logic [2:0] c, input logic [11:0] d, input bit auto_done, input string tag);
        bit sc;
        logic [23:0] e;
        @(negedge i_clk);
        n_vec++;
        if (o_cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_before: got %b want 1", tag, o_cmd_ready);
        end
        sc = model_cmd(c, d);
        exp_q.push_back({7'(m_col), 5'(m_row), 12'(m_row * COLS + m_col)});
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        i_cmd_data  = d;
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        @(negedge i_clk);
        e = exp_q[0];
        n_vec++;
        if (o_cur_col !== e[23:17] || o_cur_row !== e[16:12]) begin
            n_err++; $display("FAIL %s pos: got col=%0d row=%0d want col=%0d row=%0d",
                              tag, o_cur_col, o_cur_row, e[23:17], e[16:12]);
        end
        n_vec++;
        if (o_cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL %s ready_busy: got %b want 0", tag, o_cmd_ready);
        end
        @(negedge i_clk);
        e = exp_q.pop_front();
        n_vec++;
        if (o_cur_pos_addr !== e[11:0]) begin
            n_err++; $display("FAIL %s addr: got %0d want %0d", tag, o_cur_pos_addr, e[11:0]);
        end
        n_vec++;
        if (o_scroll_req !== sc || o_cmd_ready !== !sc) begin
            n_err++; $display("FAIL %s scroll/ready: got req=%b rdy=%b want req=%b rdy=%b",
                              tag, o_scroll_req, o_cmd_ready, sc, !sc);
        end
        if (sc && auto_done) begin
            pulse_done();
            @(negedge i_clk);
            n_vec++;
            if (o_scroll_req !== 1'b0 || o_cmd_ready !== 1'b1) begin
                n_err++; $display("FAIL %s scroll_release: got req=%b rdy=%b want req=0 rdy=1",
                                  tag, o_scroll_req, o_cmd_ready);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge i_clk);
        n_vec++;
        if (o_cur_col !== 7'd0 || o_cur_row !== 5'd0 || o_cur_pos_addr !== 12'd0) begin
            n_err++; $display("FAIL reset_pos: got col=%0d row=%0d addr=%0d want 0/0/0",
                              o_cur_col, o_cur_row, o_cur_pos_addr);
        end
        n_vec++;
        if (o_cmd_ready !== 1'b1 || o_scroll_req !== 1'b0) begin
            n_err++; $display("FAIL reset_hs: got rdy=%b req=%b want rdy=1 req=0", o_cmd_ready, o_scroll_req);
        end
        n_vec++;
        if (o_cur_visible !== i_cursor_en) begin
            n_err++; $display("FAIL reset_vis: got %b want %b", o_cur_visible, i_cursor_en);
        end
    endtask

    task automatic test_set();
        send(3'd7, {5'd5, 7'd10}, 1'b1, "set_5_10");
        send(3'd7, {5'd3, 7'd80}, 1'b1, "set_bad_col");
        send(3'd7, {5'd30, 7'd0}, 1'b1, "set_bad_row");
        send(3'd0, 12'd0, 1'b1, "nop");
    endtask

    task automatic test_wrap();
        send(3'd7, {5'd0, 7'd79}, 1'b1, "set_0_79");
        send(3'd1, 12'd0, 1'b1, "right_wrap");
        send(3'd2, 12'd0, 1'b1, "left_wrap");
        send(3'd5, 12'd0, 1'b1, "home");
        send(3'd2, 12'd0, 1'b1, "left_origin");
        send(3'd3, 12'd0, 1'b1, "up_origin");
        send(3'd4, 12'd0, 1'b1, "down");
        send(3'd1, 12'd0, 1'b1, "right");
        send(3'd6, 12'd0, 1'b1, "newline");
        send(3'd7, {5'd29, 7'd79}, 1'b1, "set_last");
        send(3'd1, 12'd0, 1'b1, "right_last_scroll");
    endtask

    task automatic test_scroll();
        send(3'd7, {5'd29, 7'd40}, 1'b1, "set_29_40");
        send(3'd6, 12'd0, 1'b0, "newline_scroll");
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd       = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            n_vec++;
            if (o_cmd_ready !== 1'b0 || o_scroll_req !== 1'b1 || o_cur_col !== 7'd0 || o_cur_row !== 5'd29) begin
                n_err++; $display("FAIL scroll_hold: got rdy=%b req=%b col=%0d row=%0d want 0/1/0/29",
                                  o_cmd_ready, o_scroll_req, o_cur_col, o_cur_row);
            end
            n_vec++;
            if (o_cur_visible !== 1'b0) begin
                n_err++; $display("FAIL scroll_vis: got %b want 0", o_cur_visible);
            end
        end
        i_cmd_valid = 1'b0;
        pulse_done();
        @(negedge i_clk);
        n_vec++;
        if (o_scroll_req !== 1'b0 || o_cmd_ready !== 1'b1 || o_cur_pos_addr !== 12'd2320) begin
            n_err++; $display("FAIL scroll_done: got req=%b rdy=%b addr=%0d want 0/1/2320",
                              o_scroll_req, o_cmd_ready, o_cur_pos_addr);
        end
        pulse_done();
        send(3'd3, 12'd0, 1'b1, "up_after_idle_done");
    endtask

    task automatic test_back_to_back();
        send(3'd5, 12'd0, 1'b1, "home_b2b");
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd       = 3'd1;
        repeat (10) @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) void'(model_cmd(3'd1, 12'd0));
        exp_q.push_back({7'(m_col), 5'(m_row), 12'(m_row * COLS + m_col)});
        repeat (2) @(negedge i_clk);
        begin
            logic [23:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (o_cur_col !== e[23:17] || o_cur_row !== e[16:12] || o_cur_pos_addr !== e[11:0]) begin
                n_err++; $display("FAIL b2b_rate: got col=%0d row=%0d addr=%0d want %0d/%0d/%0d",
                                  o_cur_col, o_cur_row, o_cur_pos_addr, e[23:17], e[16:12], e[11:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  c;
            logic [11:0] d;
            c = 3'($urandom_range(0, 7));
            d = {5'($urandom_range(0, 31)), 7'($urandom_range(0, 127))};
            send(c, d, 1'b1, "random");
        end
    endtask

    task automatic test_reset_in_scroll();
        send(3'd7, {5'd29, 7'd5}, 1'b1, "set_29_5");
        send(3'd4, 12'd0, 1'b0, "down_scroll");
        do_reset();
        @(negedge i_clk);
        n_vec++;
        if (o_scroll_req !== 1'b0 || o_cmd_ready !== 1'b1 || o_cur_pos_addr !== 12'd0 ||
            o_cur_col !== 7'd0 || o_cur_row !== 5'd0) begin
            n_err++; $display("FAIL rst_scroll: got req=%b rdy=%b addr=%0d col=%0d row=%0d want 0/1/0/0/0",
                              o_scroll_req, o_cmd_ready, o_cur_pos_addr, o_cur_col, o_cur_row);
        end
        pulse_done();
        @(negedge i_clk);
        n_vec++;
        if (o_scroll_req !== 1'b0 || o_cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_late_done: got req=%b rdy=%b want 0/1", o_scroll_req, o_cmd_ready);
        end
    endtask

    task automatic test_blink();
        logic exp_vis[5];
        do_reset();
        i_cursor_en = 1'b1;
`ifdef VGA_CURSOR_BLINK_EN
        exp_vis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_vis = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 3; i++) begin
            pulse_strobe();
            @(negedge i_clk);
            n_vec++;
            if (o_cur_visible !== exp_vis[i]) begin
                n_err++; $display("FAIL blink_strobe%0d: got %b want %b", i, o_cur_visible, exp_vis[i]);
            end
        end
        send(3'd1, 12'd0, 1'b1, "right_blink");
        n_vec++;
        if (o_cur_visible !== 1'b1) begin
            n_err++; $display("FAIL blink_restart: got %b want 1", o_cur_visible);
        end
        for (int i = 3; i < 5; i++) begin
            pulse_strobe();
            @(negedge i_clk);
            n_vec++;
            if (o_cur_visible !== exp_vis[i]) begin
                n_err++; $display("FAIL blink_after%0d: got %b want %b", i, o_cur_visible, exp_vis[i]);
            end
        end
        i_cursor_en = 1'b0;
        @(negedge i_clk);
        n_vec++;
        if (o_cur_visible !== 1'b0) begin
            n_err++; $display("FAIL cursor_dis: got %b want 0", o_cur_visible);
        end
        i_cursor_en = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_set();
        test_wrap();
        test_scroll();
        test_back_to_back();
        test_random();
        test_reset_in_scroll();
        test_blink();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1);
    end

endmodule

// File: doc/vga_cursor_ctrl.md
Name: vga_cursor_ctrl

Overview:
Owns the text-mode cursor position for the VGA text controller. Executes cursor-movement commands from the host and character-write path, and maintains column, row and the linear character address consumed by the cursor coordinate comparator. Requests a screen scroll when the cursor moves past the last row. Generates the cursor visibility / blink signal from frame strobes.

Parameters:
COLS, 80, characters per row (max 127)
ROWS, 30, text rows (max 31)
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
i_clk  in  1  pixel/system clock
i_rst  in  1  synchronous reset, active-high
i_cmd_valid  in  1  command strobe; accepted when i_cmd_valid & o_cmd_ready at rising edge
o_cmd_ready  out  1  block can accept a command
i_cmd  in  3  0 NOP, 1 RIGHT, 2 LEFT, 3 UP, 4 DOWN, 5 HOME, 6 NEWLINE, 7 SET
i_cmd_data  in  12  SET only: [6:0] column, [11:7] row
i_frame_strobe  in  1  one-cycle pulse per frame (vsync start)
i_cursor_en  in  1  cursor display enable
i_scroll_done  in  1  one-cycle pulse from scroll engine
o_scroll_req  out  1  level, held until i_scroll_done
o_cur_col  out  7  current column
o_cur_row  out  5  current row
o_cur_pos_addr  out  12  row*COLS+col, registered
o_cur_visible  out  1  cursor shall be drawn this frame

Behaviour:
- Reset: col=0, row=0, o_cur_pos_addr=0, o_cmd_ready=1, o_scroll_req=0, blink phase=visible, blink counter=0, state IDLE. Reset at any cycle, including SCROLL_WAIT, aborts immediately to these values.
- FSM states: IDLE, EXEC, SCROLL_WAIT.
- IDLE: o_cmd_ready=1. On accept at edge N: col/row update at edge N; state goes to EXEC, or to SCROLL_WAIT if a scroll is needed. NOP is accepted with no position change and still goes to EXEC.
- EXEC: o_cmd_ready=0; o_cur_pos_addr <= row*COLS+col at edge N+1; return to IDLE. Throughput is one command per 2 cycles.
- SCROLL_WAIT: o_cmd_ready=0; o_scroll_req=1; o_cur_pos_addr updated on entry+1. On i_scroll_done: o_scroll_req=0 and state goes to IDLE. i_scroll_done seen in IDLE/EXEC is ignored.
- RIGHT: col+1. At col=COLS-1: col=0, row+1. At last row this gives col=0, row=ROWS-1 and a scroll.
- LEFT: col-1. At col=0,row>0: col=COLS-1, row-1. At (0,0): no change.
- UP: row-1; saturates at 0.
- DOWN: row+1. At row=ROWS-1: row unchanged plus a scroll.
- HOME: col=0, row=0.
- NEWLINE: col=0, row+1. At last row: row unchanged plus a scroll.
- SET: loads col/row from i_cmd_data. If col>=COLS or row>=ROWS the position is unchanged and the command completes normally (no error flag).
- Address arithmetic: 12-bit unsigned; COLS*ROWS <= 4096 required.
- Blink: counter increments on i_frame_strobe. When it reaches BLINK_FRAMES-1 together with a strobe, counter=0 and phase toggles.
- Any accepted command other than NOP forces phase=visible and counter=0 at the accept edge. If a strobe arrives in the same cycle, the restart wins.
- o_cur_visible = i_cursor_en & phase (combinational from registered phase). o_cur_visible is 0 while in SCROLL_WAIT.

Optional Feature:
VGA_CURSOR_BLINK_EN
- Defined: blink counter and phase logic as described above.
- Undefined: no blink counter or phase register; i_frame_strobe is unused; o_cur_visible = i_cursor_en & (state != SCROLL_WAIT).

Test Plan:
- Reset: i_rst high 2 cycles, then low -> col=0, row=0, addr=0, ready=1, scroll_req=0, visible=i_cursor_en.
- SET data {row=5,col=10} -> col=10, row=5 at accept edge; addr=410 one cycle later; ready back to 1 after 2 cycles.
- SET col=79,row=0, then RIGHT -> col=0, row=1, addr=80. Then LEFT -> col=79, row=0, addr=79. At (0,0), LEFT and UP leave addr=0.
- SET row=29,col=40, then NEWLINE -> col=0, row=29, addr=2320, scroll_req=1, ready=0. Hold 5 cycles; a command presented during the wait is not accepted. i_scroll_done pulse -> scroll_req=0, ready=1 next cycle.
- BLINK_FRAMES=2, cursor_en=1, strobe every 10 cycles -> visible toggles every 2 strobes. RIGHT issued mid-hidden phase -> visible=1 and the count restarts. cursor_en=0 -> visible=0.
- Reset asserted during SCROLL_WAIT -> next cycle scroll_req=0, ready=1, addr=0. A later i_scroll_done has no effect.
